obi_mem_arbiter: RTL
====================

OBI_MEM_ARBITER -- requirements
Module: obi_mem_arbiter
Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, meaning address width on all ports.
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 2, meaning max accepted-but-unanswered transactions (1..4).
REQ-003 SHALL have port clk_i  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port instr_req_i  input  1  instruction fetch request.
REQ-006 SHALL have port instr_gnt_o  output  1  instruction address phase accepted.
REQ-007 SHALL have port instr_rvalid_o  output  1  instruction read data valid.
REQ-008 SHALL have port instr_addr_i  input  ADDR_WIDTH  fetch address.
REQ-009 SHALL have port instr_rdata_o  output  32  fetch read data.
REQ-010 SHALL have port data_req_i  input  1  load/store request.
REQ-011 SHALL have port data_gnt_o  output  1  data address phase accepted.
REQ-012 SHALL have port data_rvalid_o  output  1  data response valid.
REQ-013 SHALL have port data_addr_i  input  ADDR_WIDTH  load/store address.
REQ-014 SHALL have port data_we_i  input  1  write enable.
REQ-015 SHALL have port data_be_i  input  4  byte enables.
REQ-016 SHALL have port data_wdata_i  input  32  write data.
REQ-017 SHALL have port data_rdata_o  output  32  load read data.
REQ-018 SHALL have port mem_req_o  output  1  shared memory request.
REQ-019 SHALL have port mem_gnt_i  input  1  memory accepts address phase.
REQ-020 SHALL have port mem_rvalid_i  input  1  memory response valid.
REQ-021 SHALL have ports mem_addr_o (ADDR_WIDTH), mem_we_o (1), mem_be_o (4), mem_wdata_o (32), all output, carrying the selected requester's address phase.
REQ-022 SHALL have port mem_rdata_i  input  32  memory read data, broadcast to instr_rdata_o and data_rdata_o.
Function
REQ-023 SHALL, in state IDLE, select the sole requester, or, when both request, data (fixed priority build).
REQ-024 SHALL drive mem_req_o = selected req AND outstanding count < MAX_OUTSTANDING; zero added cycles req->mem_req and mem_gnt->gnt.
REQ-025 SHALL assert only the selected port's gnt, equal to mem_req_o AND mem_gnt_i.
REQ-026 SHALL move IDLE->LOCKED when mem_req_o=1 and mem_gnt_i=0, hold selection and address phase unchanged in LOCKED, return to IDLE on the cycle after gnt.
REQ-027 SHALL, for instruction selection, drive mem_we_o=0, mem_be_o=4'hF, mem_wdata_o=0.
REQ-028 SHALL push source id into a MAX_OUTSTANDING-deep FIFO on each accepted address phase and pop on mem_rvalid_i, routing rvalid combinationally to the FIFO head's port only.
REQ-029 SHALL keep count unchanged on simultaneous push and pop; FIFO full blocks mem_req_o until a pop (same-cycle pop frees the slot).
REQ-030 SHALL ignore mem_rvalid_i when FIFO empty (no rvalid out, no pointer change).
Reset
REQ-031 SHALL, while rst_ni=0 at a clock edge, force state IDLE, count 0, FIFO pointers 0, round-robin pointer favoring data; all gnt/rvalid/mem_req_o outputs 0 during reset; responses outstanding at reset are discarded.
Configuration
REQ-032 SHALL, with OBI_ARB_ROUND_ROBIN_EN defined, arbitrate contention round-robin (last-granted port loses next tie); without it, fixed data priority per REQ-023.
Structure
REQ-033 SHALL place source enum (SRC_INSTR, SRC_DATA), state enum (IDLE, LOCKED) and MAX_OUTSTANDING upper bound in package obi_arb_pkg; response FIFO SHALL be sub-module obi_arb_resp_fifo.
Verification
REQ-034 Both req same cycle, mem_gnt_i=1 -> data_gnt_o=1, instr_gnt_o=0; default build instr granted next cycle when data drops.
REQ-035 Instr req at 0x80, mem_gnt_i low 3 cycles -> mem_addr_o stays 0x80, data req arriving cycle 2 not granted until instr gnt.
REQ-036 Two accepted ops (data then instr), MAX_OUTSTANDING=2 -> third request stalled (mem_req_o=0); rvalids route data then instr in order.
REQ-037 ROUND_ROBIN_EN, both req continuously, gnt always 1 -> grants alternate data, instr, data, instr.
REQ-038 rst_ni low with one outstanding, then late mem_rvalid_i -> no rvalid on either port, count 0.

Source files
------------

// File: rtl/obi_arb_pkg.sv
// Shared types for the two-port OBI memory arbiter.
// Source ids, FSM states and the outstanding-depth ceiling.
package obi_arb_pkg;

    typedef enum logic {
        SRC_INSTR = 1'b0,
        SRC_DATA  = 1'b1
    } src_e;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    localparam int MAX_OUTSTANDING_LIMIT = 4;

    function automatic src_e other_src(input src_e s);
        return (s == SRC_DATA) ? SRC_INSTR : SRC_DATA;
    endfunction

endpackage

// File: rtl/obi_mem_arbiter_if.sv
// One OBI channel: address phase (req/gnt) and response phase (rvalid).
// master drives the address phase, slave returns grants and responses.
interface obi_mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  req;
    logic                  gnt;
    logic                  rvalid;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  we;
    logic [3:0]            be;
    logic [31:0]           wdata;
    logic [31:0]           rdata;

    modport master (
        output req, addr, we, be, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, addr, we, be, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/obi_arb_resp_fifo.sv
// In-order FIFO of source ids for accepted-but-unanswered transactions.
// A pop in the same cycle as a push on a full FIFO frees the slot.
module obi_arb_resp_fifo
    import obi_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic push_i,
    input  src_e src_i,
    input  logic pop_i,
    output src_e head_o,
    output logic empty_o,
    output logic full_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    src_e          mem_q [DEPTH];
    logic [PW-1:0] wptr_q;
    logic [PW-1:0] rptr_q;
    logic [CW-1:0] cnt_q;
    logic          push_ok;
    logic          pop_ok;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_ok);
    assign head_o  = mem_q[rptr_q];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push_ok) wptr_q <= nxt(wptr_q);
            if (pop_ok)  rptr_q <= nxt(rptr_q);
            if (push_ok && !pop_ok) cnt_q <= cnt_q + CW'(1);
            if (pop_ok && !push_ok) cnt_q <= cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wptr_q] <= src_i;
    end

endmodule

// File: rtl/obi_mem_arbiter.sv
// Two-port (instr/data) OBI arbiter onto one memory port.
// Define OBI_ARB_ROUND_ROBIN_EN for round-robin ties; default is data priority.
module obi_mem_arbiter
    import obi_arb_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,

    input  logic                  instr_req_i,
    output logic                  instr_gnt_o,
    output logic                  instr_rvalid_o,
    input  logic [ADDR_WIDTH-1:0] instr_addr_i,
    output logic [31:0]           instr_rdata_o,

    input  logic                  data_req_i,
    output logic                  data_gnt_o,
    output logic                  data_rvalid_o,
    input  logic [ADDR_WIDTH-1:0] data_addr_i,
    input  logic                  data_we_i,
    input  logic [3:0]            data_be_i,
    input  logic [31:0]           data_wdata_i,
    output logic [31:0]           data_rdata_o,

    output logic                  mem_req_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic                  mem_we_o,
    output logic [3:0]            mem_be_o,
    output logic [31:0]           mem_wdata_o,
    input  logic [31:0]           mem_rdata_i
);
    state_e                state_q;
    src_e                  lock_src_q;
    logic [ADDR_WIDTH-1:0] lock_addr_q;
    logic                  lock_we_q;
    logic [3:0]            lock_be_q;
    logic [31:0]           lock_wdata_q;

    src_e sel;
    src_e tie_src;
    src_e head;
    logic sel_req;
    logic fifo_empty;
    logic fifo_full;
    logic slot_free;
    logic accept;
    logic rsp;

`ifdef OBI_ARB_ROUND_ROBIN_EN
    src_e rr_prio_q;

    // The port granted last loses the next tie.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rr_prio_q <= SRC_DATA;
        end else if (accept) begin
            rr_prio_q <= other_src(sel);
        end
    end

    assign tie_src = rr_prio_q;
`else
    assign tie_src = SRC_DATA;
`endif

    always_comb begin
        sel = SRC_DATA;
        priority case (1'b1)
            state_q == LOCKED:        sel = lock_src_q;
            instr_req_i & data_req_i: sel = tie_src;
            instr_req_i:              sel = SRC_INSTR;
            default:                  sel = SRC_DATA;
        endcase
    end

    assign sel_req   = (sel == SRC_DATA) ? data_req_i : instr_req_i;
    assign slot_free = ~fifo_full | (mem_rvalid_i & ~fifo_empty);
    assign mem_req_o = rst_ni & sel_req & slot_free;
    assign accept    = mem_req_o & mem_gnt_i;

    assign instr_gnt_o = accept & (sel == SRC_INSTR);
    assign data_gnt_o  = accept & (sel == SRC_DATA);

    always_comb begin
        mem_addr_o  = instr_addr_i;
        mem_we_o    = 1'b0;
        mem_be_o    = 4'hF;
        mem_wdata_o = '0;
        priority case (1'b1)
            state_q == LOCKED: begin
                mem_addr_o  = lock_addr_q;
                mem_we_o    = lock_we_q;
                mem_be_o    = lock_be_q;
                mem_wdata_o = lock_wdata_q;
            end
            sel == SRC_DATA: begin
                mem_addr_o  = data_addr_i;
                mem_we_o    = data_we_i;
                mem_be_o    = data_be_i;
                mem_wdata_o = data_wdata_i;
            end
            default: ;
        endcase
    end

    // Address phase is frozen once offered and not yet granted.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            lock_src_q   <= SRC_DATA;
            lock_addr_q  <= '0;
            lock_we_q    <= 1'b0;
            lock_be_q    <= '0;
            lock_wdata_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (mem_req_o && !mem_gnt_i) begin
                        state_q      <= LOCKED;
                        lock_src_q   <= sel;
                        lock_addr_q  <= mem_addr_o;
                        lock_we_q    <= mem_we_o;
                        lock_be_q    <= mem_be_o;
                        lock_wdata_q <= mem_wdata_o;
                    end
                end
                LOCKED: begin
                    if (accept || !sel_req) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    obi_arb_resp_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_resp_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (accept),
        .src_i   (sel),
        .pop_i   (mem_rvalid_i & rst_ni),
        .head_o  (head),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    assign rsp            = rst_ni & mem_rvalid_i & ~fifo_empty;
    assign instr_rvalid_o = rsp & (head == SRC_INSTR);
    assign data_rvalid_o  = rsp & (head == SRC_DATA);
    assign instr_rdata_o  = mem_rdata_i;
    assign data_rdata_o   = mem_rdata_i;

endmodule
